imem_loader: RTL

- Boot-time loader upstream of the processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Writes the words into instruction memory at consecutive word addresses.
- Holds the processor core in reset until the image is fully loaded; flags malformed or stalled images.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// =============================================================================
// Package  : cpu_pkg
// Shared loader state encoding, stream/word widths and address helper.
// Revision : 1.0
// =============================================================================
package cpu_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    // Byte address of a word slot relative to the image base.
    function automatic logic [WORD_W-1:0] word_byte_addr(
        input logic [WORD_W-1:0] base,
        input logic [WORD_W-1:0] index
    );
        return base + (index << 2);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// =============================================================================
// Interface : imem_loader_if
// Byte-stream handshake into the loader and word-write port towards the IMEM.
// Revision  : 1.0
// =============================================================================
interface imem_loader_if;
    import cpu_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              im_we;
    logic [WORD_W-1:0] im_addr;
    logic [WORD_W-1:0] im_wdata;

    // Stream source / memory sink side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// =============================================================================
// Module   : byte_packer
// Shifts accepted bytes into a big-endian word and pulses word_full on the 4th.
// Revision : 1.0
// =============================================================================
module byte_packer
    import cpu_pkg::*;
(
    input  wire logic              clock,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              accept,
    input  wire logic [BYTE_W-1:0] byte_in,
    output logic      [WORD_W-1:0] word,
    output logic                   word_full
);

    // Header and data words share one length, so a single counter frames both.
    localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_count;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (accept) begin
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], byte_in};
            r_count <= r_count + 2'd1;
        end
    end

    // The completed word includes the byte being accepted this cycle.
    assign word      = {r_shift, byte_in};
    assign word_full = accept && (r_count == LAST_BYTE);

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// =============================================================================
// Module   : imem_loader
// Boot loader: writes a length-prefixed big-endian image into IMEM, then
// releases the core from reset; flags oversized or stalled images.
// Revision : 1.0
// =============================================================================
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS    = 256,
    parameter logic [WORD_W-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned       TIMEOUT_CYCLES = 65535
) (
    input  wire logic    clock,
    input  wire logic    rst,
    input  wire logic    start,
    imem_loader_if.slave bus,
    output logic         cpu_rst_n,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  r_nwords;
    logic [TMO_W-1:0]  r_tmo;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_clear;
    logic              w_word_full;
    logic              w_tmo_hit;
    logic              w_last_word;
    logic [WORD_W-1:0] w_word;

    assign w_in_ready  = (r_state == ST_HDR) || (r_state == ST_LOAD);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_last_word = ((r_index + IDX_W'(1)) == r_nwords);

    assign bus.in_ready = w_in_ready;
    assign bus.im_addr  = r_addr;
    assign bus.im_wdata = r_wdata;

    byte_packer u_packer (
        .clock     (clock),
        .rst       (rst),
        .clear     (w_clear),
        .accept    (w_accept),
        .byte_in   (bus.in_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        bus.im_we = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_rst_n = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                done      = (r_state == ST_DONE);
                err       = (r_state == ST_ERR);
                cpu_rst_n = (r_state == ST_DONE);
                if (start) begin
                    w_next  = ST_HDR;
                    w_clear = 1'b1;
                end
            end
            ST_HDR: begin
                busy = 1'b1;
                // Full 32-bit compare so stray upper header bits are rejected.
                if (w_word_full) begin
                    if (w_word == '0) begin
                        w_next = ST_DONE;
                    end else if (w_word > WORD_W'(DEPTH_WORDS)) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next  = ST_LOAD;
                        w_clear = 1'b1;
                    end
                end else if (!w_accept && w_tmo_hit) begin
                    w_next = ST_ERR;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (w_word_full) begin
                    w_next = ST_WR;
                end else if (!w_accept && w_tmo_hit) begin
                    w_next = ST_ERR;
                end
            end
            ST_WR: begin
                busy      = 1'b1;
                bus.im_we = 1'b1;
                w_next    = w_last_word ? ST_DONE : ST_LOAD;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_index  <= '0;
            r_nwords <= '0;
            r_tmo    <= '0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_index <= '0;
                        r_tmo   <= '0;
                        r_addr  <= BASE_ADDR;
                    end
                end
                ST_HDR, ST_LOAD: begin
                    if (w_accept) begin
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                    if (w_word_full && (r_state == ST_HDR)) begin
                        r_nwords <= w_word[IDX_W-1:0];
                        r_index  <= '0;
                    end
                    if (w_word_full && (r_state == ST_LOAD)) begin
                        r_addr  <= word_byte_addr(BASE_ADDR, WORD_W'(r_index));
                        r_wdata <= w_word;
                    end
                end
                ST_WR: begin
                    r_index <= r_index + IDX_W'(1);
                end
                default: begin
                    r_index <= '0;
                end
            endcase
        end
    end

endmodule : imem_loader
`default_nettype wire
